// File: rtl/shift_reg_piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shift_reg_piso_pkg;

  // Default word length and the bit-counter width that covers it.
  localparam int unsigned PISO_SHLEN_DEF = 6;
  localparam int unsigned PISO_CNTW_DEF  = 3;

  // Frame FSM encoding. Code 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } piso_state_e;

endpackage

// File: rtl/shift_reg_piso_if.sv
// Parallel-word load channel feeding the serializer (valid/ready).
// Latency: wires only.
// Backpressure: producer holds ld_vld/ld_dat until it sees ld_rdy on an edge.
interface shift_reg_piso_if #(
  parameter int SHLEN = 6
);

  logic             ld_vld;
  logic [SHLEN-1:0] ld_dat;
  logic             ld_rdy;

  // Word producer side.
  modport master (
    output ld_vld,
    output ld_dat,
    input  ld_rdy
  );

  // Serializer side.
  modport slave (
    input  ld_vld,
    input  ld_dat,
    output ld_rdy
  );

endinterface

// File: rtl/shift_reg_piso_bit_cnt.sv
// Bit counter for one serial frame; flags the final bit position.
// Latency: count updates on the edge where en is high; last is combinational from the count.
// Backpressure: none; clr wins over en.
module shift_reg_piso_bit_cnt #(
  parameter int SHLEN = 6,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [CNTW-1:0] cnt_val,
  output logic            last
);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  // Next count: clear at frame boundaries, advance once per shifted bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // Counter register, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_val = cnt_q;
  assign last    = (cnt_q == CNTW'(SHLEN - 1));

endmodule

// File: rtl/shift_reg_piso.sv
// Serializes an SHLEN-bit word, one bit per tick, MSB- or LSB-first as chosen at load time.
// Latency: first bit on sout the cycle after accept; done pulses the cycle after the last tick edge.
// Backpressure: ld_rdy is low from accept until one cycle after done; tick paces the output.
module shift_reg_piso
  import shift_reg_piso_pkg::*;
#(
  parameter int SHLEN = PISO_SHLEN_DEF,
  parameter int CNTW  = PISO_CNTW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              dir,
  shift_reg_piso_if.slave   ld,
  output logic              sout,
  output logic              sout_en,
  output logic              busy,
  output logic              done
);

  piso_state_e      state_q;
  piso_state_e      state_d;
  logic [SHLEN-1:0] sreg_q;
  logic [SHLEN-1:0] sreg_d;
  logic             dir_q;
  logic             dir_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             ld_rdy_q;
  logic             ld_rdy_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_last;
  logic [CNTW-1:0]  cnt_val;
  logic             cnt_bad;

  shift_reg_piso_bit_cnt #(
    .SHLEN (SHLEN),
    .CNTW  (CNTW)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt_val (cnt_val),
    .last    (cnt_last)
  );

  // A count at or beyond SHLEN can only come from corruption; the extra
  // bit keeps the compare correct when SHLEN fills the counter exactly.
  assign cnt_bad = ({1'b0, cnt_val} >= (CNTW + 1)'(SHLEN));

  // Frame sequencing: load in IDLE, shift on ticks, one-cycle DONE, back to IDLE.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ticks are ignored here, including one coincident with the load.
        if (ld.ld_vld) begin
          sreg_d  = ld.ld_dat;
          dir_d   = dir;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_bad) begin
          sreg_d  = '0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (tick) begin
          // Move the next bit to the output end and zero-fill behind it.
          if (dir_q) begin
            sreg_d = {sreg_q[SHLEN-2:0], 1'b0};
          end else begin
            sreg_d = {1'b0, sreg_q[SHLEN-1:1]};
          end
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered decodes of the next state.
    busy_d   = (state_d == ST_SHIFT);
    done_d   = (state_d == ST_DONE);
    ld_rdy_d = (state_d == ST_IDLE);
  end

  // State, data and status registers; reset lands in IDLE ready to accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ld_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ld_rdy_q <= ld_rdy_d;
    end
  end

  // Serial bit comes straight off the register end selected by the frame
  // direction; the strobe follows tick so the SIPO samples on the shift edge.
  assign sout      = busy_q & (dir_q ? sreg_q[SHLEN-1] : sreg_q[0]);
  assign sout_en   = busy_q & tick;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ld.ld_rdy = ld_rdy_q;

endmodule

// File: tb/tb_shift_reg_piso.sv
// Directed and randomized checks of the serializer against a frame-level model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_shift_reg_piso;

  localparam int SHLEN = 6;
  localparam int CNTW  = 3;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic dir;
  logic sout;
  logic sout_en;
  logic busy;
  logic done;

  int total = 0;
  int bad   = 0;

  shift_reg_piso_if #(.SHLEN(SHLEN)) ld_if ();

  shift_reg_piso #(
    .SHLEN (SHLEN),
    .CNTW  (CNTW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .dir     (dir),
    .ld      (ld_if.slave),
    .sout    (sout),
    .sout_en (sout_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One idle cycle: nothing may shift, whatever tick does.
  task automatic idle_step(input logic t);
    @(posedge clk); #1;
    ld_if.ld_vld = 1'b0;
    tick = t;
    #1;
    chk("idle_rdy", ld_if.ld_rdy, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_sout", sout, 0);
    chk("idle_sout_en", sout_en, 0);
  endtask

  // Send one word and check the whole frame. Model: the k-th strobed bit is
  // w[SHLEN-1-k] (MSB first) or w[k] (LSB first); a same-direction SIPO
  // rebuilds w from those bits. abort_after>0 resets after that many ticks.
  task automatic send_frame(input logic [SHLEN-1:0] w, input logic d, input int period,
                            input logic tick_on_load, input logic hold, input int abort_after);
    logic [SHLEN-1:0] rx;
    logic             exp_bit;
    int               k;
    int               c;
    rx = '0;
    k  = 0;
    c  = 0;

    // Accept cycle.
    @(posedge clk); #1;
    ld_if.ld_vld = 1'b1;
    ld_if.ld_dat = w;
    dir  = d;
    tick = tick_on_load;
    #1;
    chk("load_rdy", ld_if.ld_rdy, 1);
    chk("load_sout_en", sout_en, 0);

    while (k < SHLEN) begin
      @(posedge clk); #1;
      if (hold) begin
        ld_if.ld_vld = 1'b1;
        ld_if.ld_dat = 6'b010101;
        dir = ~dir;
      end else begin
        ld_if.ld_vld = 1'($urandom % 2);
        ld_if.ld_dat = SHLEN'($urandom);
        dir = 1'($urandom % 2);
      end
      if (period == 0) tick = 1'($urandom % 2);
      else             tick = ((c % period) == period - 1);
      #1;
      exp_bit = d ? w[SHLEN-1-k] : w[k];
      chk("shift_busy", busy, 1);
      chk("shift_rdy", ld_if.ld_rdy, 0);
      chk("shift_done", done, 0);
      chk("shift_sout", sout, exp_bit);
      chk("shift_sout_en", sout_en, tick);
      if (tick) begin
        if (d) rx = {rx[SHLEN-2:0], sout};
        else   rx = {sout, rx[SHLEN-1:1]};
        k++;
      end
      c++;
      if (abort_after != 0 && k == abort_after) break;
      if (c > 200) begin
        total++;
        bad++;
        $display("FAIL frame_timeout observed=%0d ticks required=%0d", k, SHLEN);
        break;
      end
    end

    if (abort_after != 0) begin
      // Reset right after the aborting tick edge; frame must vanish.
      @(posedge clk); #1;
      rst  = 1'b1;
      tick = 1'b1;
      #1;
      @(posedge clk); #1;
      rst  = 1'b0;
      tick = 1'b1;
      ld_if.ld_vld = 1'b0;
      #1;
      chk("abort_sout", sout, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rdy", ld_if.ld_rdy, 1);
      chk("abort_done", done, 0);
      chk("abort_sout_en", sout_en, 0);
      repeat (3) idle_step(1'b1);
      return;
    end

    chk("sipo_word", 32'(rx), 32'(w));

    // DONE cycle: one pulse, outputs quiet even with tick high.
    @(posedge clk); #1;
    if (!hold) ld_if.ld_vld = 1'($urandom % 2);
    tick = 1'b1;
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_rdy", ld_if.ld_rdy, 0);
    chk("done_sout", sout, 0);
    chk("done_sout_en", sout_en, 0);
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    dir  = 1'b0;
    ld_if.ld_vld = 1'b0;
    ld_if.ld_dat = '0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reset_rdy", ld_if.ld_rdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sout", sout, 0);
    chk("reset_sout_en", sout_en, 0);

    // Ticks in IDLE do nothing.
    repeat (3) idle_step(1'b1);

    // MSB first, tick every cycle.
    send_frame(6'b101100, 1'b1, 1, 1'b0, 1'b0, 0);
    // LSB first; ready must be back the cycle after DONE.
    send_frame(6'b101100, 1'b0, 1, 1'b0, 1'b0, 0);
    // Slow ticks: output held between strobes.
    send_frame(6'b110101, 1'b1, 4, 1'b0, 1'b0, 0);
    send_frame(6'b011001, 1'b0, 4, 1'b0, 1'b0, 0);
    // Pending word and toggling dir during a frame are ignored.
    send_frame(6'b101100, 1'b1, 2, 1'b0, 1'b1, 0);
    send_frame(6'b010101, 1'b1, 1, 1'b0, 1'b0, 0);
    // Reset after the 3rd tick aborts the frame.
    send_frame(6'b110011, 1'b1, 1, 1'b0, 1'b0, 3);
    // Tick coincident with the load edge must not shift.
    idle_step(1'b1);
    send_frame(6'b100110, 1'b1, 1, 1'b1, 1'b0, 0);
    send_frame(6'b011010, 1'b0, 3, 1'b1, 1'b0, 0);

    // Randomized frames.
    for (int i = 0; i < 12; i++) begin
      send_frame(SHLEN'($urandom), 1'($urandom % 2), int'($urandom_range(0, 4)),
                 1'($urandom % 2), 1'b0, 0);
    end
    idle_step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
